bloque: RTL and testbench

BLOQUE -- requirements
Module: bloque

---
 rtl/bloque_pkg.sv | 34 +++
 rtl/bloque_dct4_butterfly.sv | 51 +++++
 rtl/bloque.sv | 81 ++++++++
 tb/tb_bloque.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bloque_pkg.sv
// ---------------------------------------------------------------------------
// bloque_pkg
// Shared definitions for the HEVC 4-point forward integer DCT block:
//   - default sample/coefficient widths (WIDTH_Y must equal WIDTH_X + 8)
//   - DCT basis constants C64, C83, C36
//   - shift_add_mul: constant multiply built from shifts and adds only
// ---------------------------------------------------------------------------
package bloque_pkg;

    localparam int unsigned WIDTH_X_DEF = 9;
    localparam int unsigned WIDTH_Y_DEF = 17;

    localparam logic [7:0] C64 = 8'd64;
    localparam logic [7:0] C83 = 8'd83;
    localparam logic [7:0] C36 = 8'd36;

    // Multiply a signed operand by an 8-bit constant. With k constant at the
    // call site only the set bits survive elaboration, leaving a pure
    // shift-and-add tree (64 -> one shift, 83 -> 4 terms, 36 -> 2 terms).
    function automatic logic signed [31:0] shift_add_mul(
        input logic signed [31:0] a,
        input logic        [7:0]  k
    );
        logic signed [31:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (k[i]) begin
                acc = acc + (a <<< i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bloque_dct4_butterfly.sv
// ---------------------------------------------------------------------------
// dct4_butterfly
// Purely combinational even/odd butterfly of the HEVC 4-point forward DCT.
//   x0..x3 : signed WIDTH_X residual samples
//   y0..y3 : signed WIDTH_Y coefficients (no rounding, no shift)
// Inputs are sign-extended to 32 bits before any arithmetic, so no
// intermediate can overflow; for 9-bit inputs every result fits 17 bits.
// ---------------------------------------------------------------------------
module dct4_butterfly
    import bloque_pkg::*;
#(
    parameter int unsigned WIDTH_X = WIDTH_X_DEF,
    parameter int unsigned WIDTH_Y = WIDTH_Y_DEF
) (
    input  logic signed [WIDTH_X-1:0] x0,
    input  logic signed [WIDTH_X-1:0] x1,
    input  logic signed [WIDTH_X-1:0] x2,
    input  logic signed [WIDTH_X-1:0] x3,
    output logic signed [WIDTH_Y-1:0] y0,
    output logic signed [WIDTH_Y-1:0] y1,
    output logic signed [WIDTH_Y-1:0] y2,
    output logic signed [WIDTH_Y-1:0] y3
);

    logic signed [31:0] xe0, xe1, xe2, xe3;
    logic signed [31:0] e0, e1, o0, o1;
    logic signed [31:0] r0, r1, r2, r3;

    always_comb begin
        xe0 = 32'(x0);
        xe1 = 32'(x1);
        xe2 = 32'(x2);
        xe3 = 32'(x3);

        e0 = xe0 + xe3;
        e1 = xe1 + xe2;
        o0 = xe0 - xe3;
        o1 = xe1 - xe2;

        r0 = shift_add_mul(e0 + e1, C64);
        r2 = shift_add_mul(e0 - e1, C64);
        r1 = shift_add_mul(o0, C83) + shift_add_mul(o1, C36);
        r3 = shift_add_mul(o0, C36) - shift_add_mul(o1, C83);
    end

    assign y0 = r0[WIDTH_Y-1:0];
    assign y1 = r1[WIDTH_Y-1:0];
    assign y2 = r2[WIDTH_Y-1:0];
    assign y3 = r3[WIDTH_Y-1:0];

endmodule

// File: rtl/bloque.sv
// ---------------------------------------------------------------------------
// bloque
// HEVC 4-point forward integer DCT with a one-clock, load-enabled output
// register stage around the combinational dct4_butterfly.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears y0..y3
//   load   : capture a new transform result on this edge
//   x0..x3 : signed WIDTH_X residual samples of one row
//   y0..y3 : registered signed WIDTH_Y coefficients (hold while load=0)
// WIDTH_Y is expected to be WIDTH_X + 8.
// ---------------------------------------------------------------------------
module bloque
    import bloque_pkg::*;
#(
    parameter int unsigned WIDTH_X = WIDTH_X_DEF,
    parameter int unsigned WIDTH_Y = WIDTH_Y_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic signed [WIDTH_X-1:0] x0,
    input  logic signed [WIDTH_X-1:0] x1,
    input  logic signed [WIDTH_X-1:0] x2,
    input  logic signed [WIDTH_X-1:0] x3,
    output logic signed [WIDTH_Y-1:0] y0,
    output logic signed [WIDTH_Y-1:0] y1,
    output logic signed [WIDTH_Y-1:0] y2,
    output logic signed [WIDTH_Y-1:0] y3
);

    logic signed [WIDTH_Y-1:0] c0, c1, c2, c3;
    logic signed [WIDTH_Y-1:0] y0_d, y1_d, y2_d, y3_d;
    logic signed [WIDTH_Y-1:0] y0_q, y1_q, y2_q, y3_q;

    dct4_butterfly #(
        .WIDTH_X (WIDTH_X),
        .WIDTH_Y (WIDTH_Y)
    ) u_butterfly (
        .x0 (x0),
        .x1 (x1),
        .x2 (x2),
        .x3 (x3),
        .y0 (c0),
        .y1 (c1),
        .y2 (c2),
        .y3 (c3)
    );

    always_comb begin
        y0_d = y0_q;
        y1_d = y1_q;
        y2_d = y2_q;
        y3_d = y3_q;
        if (load) begin
            y0_d = c0;
            y1_d = c1;
            y2_d = c2;
            y3_d = c3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y0_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
            y3_q <= '0;
        end else begin
            y0_q <= y0_d;
            y1_q <= y1_d;
            y2_q <= y2_d;
            y3_q <= y3_d;
        end
    end

    assign y0 = y0_q;
    assign y1 = y1_q;
    assign y2 = y2_q;
    assign y3 = y3_q;

endmodule

// File: tb/tb_bloque.sv
module tb_bloque;

    logic               clk;
    logic               rst;
    logic               load;
    logic signed [8:0]  x0, x1, x2, x3;
    logic signed [16:0] y0, y1, y2, y3;
    logic signed [16:0] ex0, ex1, ex2, ex3;

    int checks;
    int fails;

    bloque #(
        .WIDTH_X (9),
        .WIDTH_Y (17)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .x0   (x0),
        .x1   (x1),
        .x2   (x2),
        .x3   (x3),
        .y0   (y0),
        .y1   (y1),
        .y2   (y2),
        .y3   (y3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int a, input int b, input int c, input int d, input logic ld);
        x0   = 9'(a);
        x1   = 9'(b);
        x2   = 9'(c);
        x3   = 9'(d);
        load = ld;
    endtask

    task automatic set_exp(input int a, input int b, input int c, input int d);
        ex0 = 17'(a);
        ex1 = 17'(b);
        ex2 = 17'(c);
        ex3 = 17'(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(100, -37, 255, -256, 1'b1);
        repeat (3) step();
        set_exp(0, 0, 0, 0);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL reset_hold: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
    endtask

    task automatic test_reset_release();
        drive(100, -37, 255, -256, 1'b0);
        #2;
        rst = 1'b0;
        repeat (2) step();
        set_exp(0, 0, 0, 0);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL release_no_load: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
    endtask

    task automatic test_most_negative();
        drive(-256, -256, -256, -256, 1'b1);
        step();
        set_exp(-65536, 0, 0, 0);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL most_negative: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                drive(1, 1, 1, 1, 1'b1);
                set_exp(256, 0, 0, 0);
            end else begin
                drive(-256, -256, -256, -256, 1'b1);
                set_exp(-65536, 0, 0, 0);
            end
            step();
            checks++;
            if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                         i, y0, y1, y2, y3, ex0, ex1, ex2, ex3);
            end
        end
    endtask

    task automatic test_hold();
        drive(1, 1, 1, 1, 1'b1);
        step();
        drive(-256, -256, -256, -256, 1'b0);
        repeat (3) step();
        set_exp(256, 0, 0, 0);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL hold: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
    endtask

    task automatic test_impulse();
        drive(255, 0, 0, 0, 1'b1);
        step();
        set_exp(16320, 21165, 16320, 9180);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL impulse: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
        // impulse on x1: y = (64, 36, -64, -83) * 10
        drive(0, 10, 0, 0, 1'b1);
        step();
        set_exp(640, 360, -640, -830);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL impulse_x1: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
        // impulse on x3 negative: y = (64, -83, 64, -36) * -3
        drive(0, 0, 0, -3, 1'b1);
        step();
        set_exp(-192, 249, -192, 108);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL impulse_x3: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
    endtask

    task automatic test_extremes();
        drive(255, -256, -256, 255, 1'b1);
        step();
        set_exp(-128, 0, 65408, 0);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL extreme_even: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
        drive(255, 255, -256, -256, 1'b1);
        step();
        set_exp(-128, 60809, 0, -24017);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL extreme_odd: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
        // mixed row: e0=3, e1=-5, o0=-1, o1=-3
        drive(1, -4, -1, 2, 1'b1);
        step();
        set_exp(-128, -191, 512, 213);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL mixed: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
    endtask

    task automatic test_reset_mid_stream();
        drive(255, 0, 0, 0, 1'b1);
        step();
        // assert reset between edges: outputs must clear with no clock edge
        #2;
        rst = 1'b1;
        #1;
        set_exp(0, 0, 0, 0);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL reset_mid_stream: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1'b0);
        step();
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL post_reset_idle: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
        drive(255, 0, 0, 0, 1'b1);
        step();
        set_exp(16320, 21165, 16320, 9180);
        checks++;
        if ({y0, y1, y2, y3} !== {ex0, ex1, ex2, ex3}) begin
            fails++;
            $display("FAIL first_load_after_reset: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     y0, y1, y2, y3, ex0, ex1, ex2, ex3);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        test_reset();
        test_reset_release();
        test_most_negative();
        test_back_to_back();
        test_hold();
        test_impulse();
        test_extremes();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
